// File: rtl/pc_fetch_if.sv
// Fetch-unit bus bundle: redirect inputs, instruction-memory port and decode handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface pc_fetch_if;
    logic        should_branch;
    logic [31:0] branch_target;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic [15:0] redirect_cnt;

    modport master (
        input  should_branch, branch_target, stall,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output flush, redirect_cnt
    );

    modport slave (
        output should_branch, branch_target, stall,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready,
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  flush, redirect_cnt
    );
endinterface

// File: rtl/pc_fetch.sv
// PC / instruction-fetch front end: one outstanding imem request, a one-entry
// decode buffer, and branch redirects that squash wrong-path fetches.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_fetch_if.master  bus
);
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 16;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_inflight;
    logic [XLEN-1:0]   instr_q;
    logic [XLEN-1:0]   instr_pc_q;
    logic              buf_valid;
    logic              flush_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_valid_c;
    logic              if_valid_c;

    // A new request needs an idle port and a buffer that is empty or draining this cycle.
    always_comb begin
        req_valid_c = rst_n & (state == S_REQ) & ~bus.stall & ~bus.should_branch
                    & (~buf_valid | bus.if_ready);
        if_valid_c  = buf_valid & ~bus.should_branch;
    end

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = pc;
    assign bus.if_valid       = if_valid_c;
    assign bus.if_instr       = instr_q;
    assign bus.if_pc          = instr_pc_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_cnt   = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            pc_inflight <= '0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            buf_valid   <= 1'b0;
            flush_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            flush_q <= bus.should_branch;
            if (bus.should_branch) begin
                // Redirect wins; an outstanding fetch becomes stale unless it returns now.
                pc        <= bus.branch_target & ALIGN_MASK;
                buf_valid <= 1'b0;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                case (state)
                    S_WAIT:  state <= bus.imem_rsp_valid ? S_REQ : S_DROP;
                    S_DROP:  state <= bus.imem_rsp_valid ? S_REQ : S_DROP;
                    default: state <= S_REQ;
                endcase
            end else begin
                if (if_valid_c && bus.if_ready) begin
                    buf_valid <= 1'b0;
                end
                case (state)
                    S_REQ: begin
                        if (req_valid_c && bus.imem_req_ready) begin
                            pc_inflight <= pc;
                            pc          <= pc + XLEN'(4);
                            state       <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        if (bus.imem_rsp_valid) begin
                            instr_q    <= bus.imem_rsp_data;
                            instr_pc_q <= pc_inflight;
                            buf_valid  <= 1'b1;
                            state      <= S_REQ;
                        end
                    end
                    S_DROP: begin
                        if (bus.imem_rsp_valid) begin
                            state <= S_REQ;
                        end
                    end
                    default: state <= S_REQ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus a long randomized run, all checked
// each cycle against an outstanding-request / buffer model of the fetch rules.
module tb_pc_fetch;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_n2;
    pc_fetch_if bus();
    pc_fetch_if bus2();

    pc_fetch #(.RESET_PC(32'h0000_0100)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
    pc_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst_n(rst_n2), .bus(bus2));

    int total = 0;
    int bad   = 0;

    // stimulus knobs
    logic k_rst_n, k_stall, k_br, k_ifr, k_rdy, k2_rst, k2_br;
    logic [31:0] k_tgt;
    int k_lat;

    // memory model for dut
    logic m_pend;
    logic [31:0] m_addr;
    int m_cnt;
    // memory model for dut2 (fixed one-cycle latency)
    logic d2_pend;
    logic [31:0] d2_addr;
    int n2;

    // reference model
    logic armed;
    logic [31:0] e_pc, e_out_addr, e_instr, e_ipc;
    logic e_out, e_stale, e_bv, e_flush;
    logic [15:0] e_cnt;

    // per-cycle observations
    logic o_fire, o_reqv, o_ifv, o_acc, o_flush, o2_fire;
    logic [31:0] o_addr, o_instr, o_ipc, o2_addr;
    logic [15:0] o_cnt, o2_cnt;
    int o_cyc, o2_n, cyc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        e_pc = 32'h100; e_out = 1'b0; e_stale = 1'b0; e_out_addr = '0;
        e_bv = 1'b0; e_instr = '0; e_ipc = '0; e_flush = 1'b0; e_cnt = '0;
    endtask

    task automatic cycle();
        logic rsp, exp_req, exp_ifv;
        @(posedge clk);
        #1;
        rsp = m_pend && (m_cnt == 0);
        rst_n                  = k_rst_n;
        bus.should_branch      = k_br;
        bus.branch_target      = k_tgt;
        bus.stall              = k_stall;
        bus.if_ready           = k_ifr;
        bus.imem_req_ready     = k_rdy;
        bus.imem_rsp_valid     = rsp;
        bus.imem_rsp_data      = rsp ? mem_word(m_addr) : $urandom;
        rst_n2                 = k2_rst;
        bus2.should_branch     = k2_br;
        bus2.branch_target     = 32'h0000_3001;
        bus2.stall             = 1'b0;
        bus2.if_ready          = 1'b1;
        bus2.imem_req_ready    = 1'b1;
        bus2.imem_rsp_valid    = d2_pend;
        bus2.imem_rsp_data     = mem_word(d2_addr);
        #1;
        exp_req = k_rst_n & ~e_out & ~k_stall & ~k_br & (~e_bv | k_ifr);
        exp_ifv = e_bv & ~k_br;
        if (armed) begin
            check("req_valid", 32'(bus.imem_req_valid), 32'(exp_req));
            if (exp_req) check("req_addr", bus.imem_req_addr, e_pc);
            check("if_valid", 32'(bus.if_valid), 32'(exp_ifv));
            check("if_instr", bus.if_instr, e_instr);
            check("if_pc", bus.if_pc, e_ipc);
            check("flush", 32'(bus.flush), 32'(e_flush));
            check("redirect_cnt", 32'(bus.redirect_cnt), 32'(e_cnt));
            if (bus.if_valid) check("instr_word", bus.if_instr, mem_word(bus.if_pc));
        end
        o_fire = bus.imem_req_valid & k_rdy;
        o_reqv = bus.imem_req_valid;
        o_addr = bus.imem_req_addr;
        o_ifv  = bus.if_valid;
        o_acc  = bus.if_valid & k_ifr;
        o_flush = bus.flush;
        o_cnt  = bus.redirect_cnt;
        o_instr = bus.if_instr;
        o_ipc  = bus.if_pc;
        o_cyc  = cyc;
        o2_fire = bus2.imem_req_valid;
        o2_addr = bus2.imem_req_addr;
        o2_cnt  = bus2.redirect_cnt;
        o2_n    = n2;

        // model advance
        if (!k_rst_n) begin
            model_reset();
            armed = 1'b1;
        end else begin
            e_flush = k_br;
            if (k_br) begin
                e_pc = k_tgt & 32'hFFFF_FFFC;
                e_bv = 1'b0;
                if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
                if (e_out) begin
                    if (rsp) e_out = 1'b0;
                    else     e_stale = 1'b1;
                end
            end else begin
                if (exp_ifv && k_ifr) e_bv = 1'b0;
                if (e_out && rsp) begin
                    e_out = 1'b0;
                    if (!e_stale) begin
                        e_bv = 1'b1; e_instr = bus.imem_rsp_data; e_ipc = e_out_addr;
                    end
                end else if (exp_req && k_rdy) begin
                    e_out = 1'b1; e_stale = 1'b0; e_out_addr = e_pc; e_pc = e_pc + 32'd4;
                end
            end
        end

        // memory advance
        if (!k_rst_n) m_pend = 1'b0;
        else if (rsp) m_pend = 1'b0;
        else if (m_pend) m_cnt--;
        if (k_rst_n && bus.imem_req_valid && k_rdy) begin
            m_pend = 1'b1; m_addr = bus.imem_req_addr; m_cnt = k_lat - 1;
        end
        d2_pend = k2_rst && bus2.imem_req_valid;
        d2_addr = bus2.imem_req_addr;
        if (k2_rst && k2_br) n2++;
        cyc++;
    endtask

    task automatic wait_fire(input string name, input int lim);
        int n = 0;
        cycle();
        while (!o_fire && n < lim) begin cycle(); n++; end
        check(name, 32'(o_fire), 32'd1);
    endtask

    task automatic wait_ifv(input string name, input int lim);
        int n = 0;
        cycle();
        while (!o_ifv && n < lim) begin cycle(); n++; end
        check(name, 32'(o_ifv), 32'd1);
    endtask

    initial begin
        logic [31:0] reqs [3];
        logic [31:0] accs [3];
        logic [31:0] r2 [2];
        int nf, na, n2f, ff, fi, nfl, n;

        k_rst_n = 0; k_stall = 0; k_br = 0; k_tgt = 0; k_ifr = 1; k_rdy = 1; k_lat = 1;
        k2_rst = 0; k2_br = 0;
        m_pend = 0; m_addr = 0; m_cnt = 0; d2_pend = 0; d2_addr = 0; n2 = 0; cyc = 0;
        armed = 0;
        model_reset();

        // reset
        cycle(); cycle();
        check("rst_req_valid", 32'(o_reqv), 32'd0);
        check("rst_flush", 32'(o_flush), 32'd0);
        check("rst_cnt", 32'(o_cnt), 32'd0);

        // sequential fetch with single-cycle memory; dut2 covers PC wrap
        k_rst_n = 1; k2_rst = 1;
        nf = 0; na = 0; n2f = 0; ff = -1; fi = -1;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (o_fire && nf < 3) begin reqs[nf] = o_addr; nf++; end
            if (o_acc && na < 3) begin accs[na] = o_ipc; na++; end
            if (o_fire && ff < 0) ff = o_cyc;
            if (o_ifv && fi < 0) fi = o_cyc;
            if (o2_fire && n2f < 2) begin r2[n2f] = o2_addr; n2f++; end
        end
        check("seq_nreq", 32'(nf), 32'd3);
        check("seq_nacc", 32'(na), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("seq_req", (i < nf) ? reqs[i] : 32'hDEAD_BEEF, 32'h100 + 32'(4 * i));
            check("seq_if_pc", (i < na) ? accs[i] : 32'hDEAD_BEEF, 32'h100 + 32'(4 * i));
        end
        check("first_latency", 32'(fi - ff), 32'd2);
        check("wrap_n", 32'(n2f), 32'd2);
        check("wrap_req0", (n2f > 0) ? r2[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("wrap_req1", (n2f > 1) ? r2[1] : 32'hDEAD_BEEF, 32'h0000_0000);
        k2_br = 1;

        // redirect while waiting on a slow response
        k_lat = 3;
        wait_fire("s_wait_fire", 10);
        k_br = 1; k_tgt = 32'h0000_2003;
        cycle();
        k_br = 0;
        nfl = 0; n = 0;
        cycle();
        if (o_flush) nfl++;
        while (!o_fire && n < 12) begin cycle(); n++; if (o_flush) nfl++; end
        check("redir_fire", 32'(o_fire), 32'd1);
        check("redir_addr", o_addr, 32'h0000_2000);
        check("redir_flush_cycles", 32'(nfl), 32'd1);
        check("redir_cnt", 32'(o_cnt), 32'd1);
        wait_ifv("redir_ifv", 10);
        check("redir_first_pc", o_ipc, 32'h0000_2000);

        // redirect in the same cycle as the response
        k_lat = 2;
        wait_fire("same_fire", 10);
        n = 0;
        while (!(m_pend && m_cnt == 0) && n < 10) begin cycle(); n++; end
        k_br = 1; k_tgt = 32'h0000_3000;
        cycle();
        check("same_ifv", 32'(o_ifv), 32'd0);
        k_br = 0;
        cycle();
        check("same_ifv_next", 32'(o_ifv), 32'd0);
        check("same_reqv", 32'(o_reqv), 32'd1);
        check("same_addr", o_addr, 32'h0000_3000);

        // decode backpressure holds the buffer and blocks requests
        k_ifr = 0;
        wait_ifv("bp_fill", 8);
        nf = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (o_fire) nf++;
            check("bp_if_pc", o_ipc, 32'h0000_3000);
            check("bp_if_instr", o_instr, mem_word(32'h0000_3000));
        end
        check("bp_no_req", 32'(nf), 32'd0);
        k_ifr = 1;
        cycle();
        check("bp_drain", 32'(o_acc), 32'd1);
        check("bp_req", 32'(o_fire), 32'd1);
        check("bp_req_addr", o_addr, 32'h0000_3004);

        // redirect in S_REQ with a full buffer and decode ready
        k_ifr = 0;
        wait_ifv("full_fill", 8);
        k_ifr = 1; k_br = 1; k_tgt = 32'h0000_4000;
        cycle();
        check("full_ifv", 32'(o_ifv), 32'd0);
        check("full_reqv", 32'(o_reqv), 32'd0);
        k_br = 0;
        cycle();
        check("full_ifv_next", 32'(o_ifv), 32'd0);
        check("full_addr", o_addr, 32'h0000_4000);
        check("full_reqv_next", 32'(o_reqv), 32'd1);

        // stall does not block capture of the outstanding response
        k_stall = 1;
        wait_ifv("stall_capture", 6);
        check("stall_if_pc", o_ipc, 32'h0000_4000);
        k_stall = 0;

        // reset while a stale response is outstanding
        k_lat = 3;
        wait_fire("drop_fire", 10);
        k_br = 1; k_tgt = 32'h0000_5000;
        cycle();
        k_br = 0; k_rst_n = 0;
        cycle();
        check("drop_rst_reqv", 32'(o_reqv), 32'd0);
        k_rst_n = 1;
        cycle();
        check("drop_flush", 32'(o_flush), 32'd0);
        check("drop_cnt", 32'(o_cnt), 32'd0);
        check("drop_ifv", 32'(o_ifv), 32'd0);
        check("drop_instr", o_instr, 32'd0);
        check("drop_ipc", o_ipc, 32'd0);
        check("drop_reqv", 32'(o_reqv), 32'd1);
        check("drop_addr", o_addr, 32'h0000_0100);

        // randomized run; dut2 meanwhile saturates its redirect counter
        for (int i = 0; i < 66000; i++) begin
            k_rst_n = ($urandom_range(0, 499) != 0);
            k_stall = ($urandom_range(0, 4) == 0);
            k_br    = ($urandom_range(0, 11) == 0);
            k_tgt   = $urandom;
            k_ifr   = ($urandom_range(0, 2) != 0);
            k_rdy   = ($urandom_range(0, 3) != 0);
            k_lat   = int'($urandom_range(1, 4));
            cycle();
            if (o2_n == 65534) check("sat_fffe", 32'(o2_cnt), 32'h0000_FFFE);
            if (o2_n == 65535) check("sat_ffff", 32'(o2_cnt), 32'h0000_FFFF);
            if (o2_n == 65540) check("sat_hold", 32'(o2_cnt), 32'h0000_FFFF);
        end
        check("sat_reached", 32'(n2 > 65540), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
